// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared VGA timing definitions. It holds the horizontal state encoding, the
// default 640x480@60 horizontal and vertical timing constants, and a helper
// that gives the cyclic successor of a horizontal state.
// ---------------------------------------------------------------------------
package vga_timing_pkg;

  // Horizontal state encoding. The line order is FRONT_PORCH -> SYNC_PULSE
  // -> BACK_PORCH -> ACTIVE_VIDEO -> FRONT_PORCH.
  localparam logic [1:0] FRONT_PORCH  = 2'd0;
  localparam logic [1:0] SYNC_PULSE   = 2'd1;
  localparam logic [1:0] BACK_PORCH   = 2'd2;
  localparam logic [1:0] ACTIVE_VIDEO = 2'd3;

  // Width of the in-state pixel counter. Every segment length is 1..1024.
  localparam int H_COUNT_W = 10;

  // Default horizontal timing, in pixel ticks.
  localparam int H_ACTIVE_DEFAULT = 640;
  localparam int H_FRONT_DEFAULT  = 16;
  localparam int H_SYNC_DEFAULT   = 96;
  localparam int H_BACK_DEFAULT   = 48;

  // Default vertical timing, in lines. The vertical stage uses these.
  localparam int V_ACTIVE_DEFAULT = 480;
  localparam int V_FRONT_DEFAULT  = 10;
  localparam int V_SYNC_DEFAULT   = 2;
  localparam int V_BACK_DEFAULT   = 33;

  // Number of system clocks per pixel tick.
  localparam int PIX_DIV_DEFAULT  = 4;

  // Returns the next state in the line sequence.
  function automatic logic [1:0] next_h_state(input logic [1:0] state);
    logic [1:0] next;
    case (state)
      FRONT_PORCH: next = SYNC_PULSE;
      SYNC_PULSE:  next = BACK_PORCH;
      BACK_PORCH:  next = ACTIVE_VIDEO;
      default:     next = FRONT_PORCH;
    endcase
    return next;
  endfunction

endpackage

// File: rtl/pixel_clock_divider.sv
// ---------------------------------------------------------------------------
// pixel_clock_divider
// Generates the pixel-enable strobe. A counter runs 0..PIX_DIV-1 and wraps.
// The tick output is high while the counter holds PIX_DIV-1, so it is a
// one-clock strobe every PIX_DIV clocks. With PIX_DIV=1 the tick stays high.
//
// Ports
//   clk    in  system clock, rising edge
//   rst_n  in  asynchronous active-low reset (counter -> 0)
//   clear  in  synchronous restart (counter -> 0 at the next edge)
//   tick   out pixel-enable strobe, combinational from the counter
// ---------------------------------------------------------------------------
module pixel_clock_divider #(
  parameter int PIX_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  // Keep at least one bit so the PIX_DIV=1 build still has a legal vector.
  localparam int CNT_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PIX_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples its inputs from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || count == CNT_LAST) begin
      count <= '0;
    end else begin
      count <= count + CNT_ONE;
    end
  end

  // With PIX_DIV=1 the counter is held at 0 == CNT_LAST, so the tick is constant.
  assign tick = (count == CNT_LAST);

endmodule

// File: rtl/horizontal_state_machine.sv
// ---------------------------------------------------------------------------
// horizontal_state_machine
// Horizontal timing generator for a VGA raster. It steps through FRONT_PORCH,
// SYNC_PULSE, BACK_PORCH and ACTIVE_VIDEO once per pixel tick. It counts
// pixels within each state and signals the end of each line to the vertical
// stage. A line starts at ACTIVE_VIDEO, so the line ends on the last
// back-porch tick.
//
// Ports
//   clk_i                      in  system clock, rising edge
//   rst_n_i                    in  asynchronous active-low reset
//   sync_rst_i                 in  synchronous restart to start of active video
//   pixel_tick_o               out one-clock pixel-enable strobe
//   h_count_o[9:0]             out in-state pixel counter (pixel x when active)
//   horizontal_active_video_o  out high during ACTIVE_VIDEO
//   sync_pulse_o               out horizontal sync, active low
//   line_end_o                 out one-clock pulse on the last tick of a line
// ---------------------------------------------------------------------------
module horizontal_state_machine
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEFAULT,
  parameter int H_FRONT  = H_FRONT_DEFAULT,
  parameter int H_SYNC   = H_SYNC_DEFAULT,
  parameter int H_BACK   = H_BACK_DEFAULT,
  parameter int PIX_DIV  = PIX_DIV_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 sync_rst_i,
  output logic                 pixel_tick_o,
  output logic [H_COUNT_W-1:0] h_count_o,
  output logic                 horizontal_active_video_o,
  output logic                 sync_pulse_o,
  output logic                 line_end_o
);

  // Last in-state count of each segment. Every length is 1..1024, so the
  // value fits in the 10-bit counter.
  localparam logic [H_COUNT_W-1:0] FRONT_LAST  = H_COUNT_W'(H_FRONT - 1);
  localparam logic [H_COUNT_W-1:0] SYNC_LAST   = H_COUNT_W'(H_SYNC - 1);
  localparam logic [H_COUNT_W-1:0] BACK_LAST   = H_COUNT_W'(H_BACK - 1);
  localparam logic [H_COUNT_W-1:0] ACTIVE_LAST = H_COUNT_W'(H_ACTIVE - 1);
  localparam logic [H_COUNT_W-1:0] COUNT_ONE   = H_COUNT_W'(1);

  logic [1:0]           state;
  logic [H_COUNT_W-1:0] h_count;
  logic [H_COUNT_W-1:0] last_count;
  logic                 pixel_tick;
  logic                 at_last;

  // A restart from the vertical stage also realigns the pixel divider, so the
  // first tick after a restart comes a full PIX_DIV clocks later.
  pixel_clock_divider #(
    .PIX_DIV (PIX_DIV)
  ) u_pixel_clock_divider (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .clear (sync_rst_i),
    .tick  (pixel_tick)
  );

  // NOTE: assign a default first so no path through the case leaves
  // last_count unassigned and infers a latch.
  always_comb begin
    last_count = ACTIVE_LAST;
    case (state)
      FRONT_PORCH: last_count = FRONT_LAST;
      SYNC_PULSE:  last_count = SYNC_LAST;
      BACK_PORCH:  last_count = BACK_LAST;
      default:     last_count = ACTIVE_LAST;
    endcase
  end

  assign at_last = (h_count == last_count);

  // The restart has priority over the tick. The counter and the state
  // otherwise move only on a tick.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= FRONT_PORCH;
      h_count <= '0;
    end else if (sync_rst_i) begin
      state   <= ACTIVE_VIDEO;
      h_count <= '0;
    end else if (pixel_tick) begin
      if (at_last) begin
        state   <= next_h_state(state);
        h_count <= '0;
      end else begin
        h_count <= h_count + COUNT_ONE;
      end
    end
  end

  assign pixel_tick_o              = pixel_tick;
  assign h_count_o                 = h_count;
  assign horizontal_active_video_o = (state == ACTIVE_VIDEO);
  assign sync_pulse_o              = (state != SYNC_PULSE);

  // Mealy strobe. It depends only on the current state and the tick, so a
  // coincident sync_rst_i neither suppresses nor creates it.
  assign line_end_o = pixel_tick && (state == BACK_PORCH) && (h_count == BACK_LAST);

endmodule

// File: tb/tb_horizontal_state_machine.sv
// ---------------------------------------------------------------------------
// tb_horizontal_state_machine
// Bench for horizontal_state_machine. It builds a default instance and a
// PIX_DIV=1 instance. Randomised restarts are checked against a model that
// tracks the position in the line in pixel ticks.
// ---------------------------------------------------------------------------
module tb_horizontal_state_machine;

  localparam int H_ACTIVE = 640;
  localparam int H_FRONT  = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BACK   = 48;
  localparam int PIX_DIV  = 4;
  localparam int LINE     = H_FRONT + H_SYNC + H_BACK + H_ACTIVE;
  localparam int ACT_POS  = H_FRONT + H_SYNC + H_BACK;  // line position of x=0

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       sync_rst;
  logic       sync_rst1;

  logic       tick, active, sync_n, line_end;
  logic [9:0] h_count;
  logic       tick1, active1, sync_n1, line_end1;
  logic [9:0] h_count1;

  int checks = 0;
  int errors = 0;

  // Model state: the clock phase within a pixel, and the tick position in a
  // line. Position 0 is the first front-porch tick.
  int m_div;
  int m_pos;

  horizontal_state_machine #(
    .H_ACTIVE (H_ACTIVE), .H_FRONT (H_FRONT), .H_SYNC (H_SYNC),
    .H_BACK (H_BACK), .PIX_DIV (PIX_DIV)
  ) dut (
    .clk_i                     (clk),
    .rst_n_i                   (rst_n),
    .sync_rst_i                (sync_rst),
    .pixel_tick_o              (tick),
    .h_count_o                 (h_count),
    .horizontal_active_video_o (active),
    .sync_pulse_o              (sync_n),
    .line_end_o                (line_end)
  );

  horizontal_state_machine #(
    .H_ACTIVE (H_ACTIVE), .H_FRONT (H_FRONT), .H_SYNC (H_SYNC),
    .H_BACK (H_BACK), .PIX_DIV (1)
  ) dut1 (
    .clk_i                     (clk),
    .rst_n_i                   (rst_n),
    .sync_rst_i                (sync_rst1),
    .pixel_tick_o              (tick1),
    .h_count_o                 (h_count1),
    .horizontal_active_video_o (active1),
    .sync_pulse_o              (sync_n1),
    .line_end_o                (line_end1)
  );

  function automatic logic [9:0] exp_h(input int p);
    int x;
    if (p < H_FRONT)                    x = p;
    else if (p < H_FRONT + H_SYNC)      x = p - H_FRONT;
    else if (p < ACT_POS)               x = p - H_FRONT - H_SYNC;
    else                                x = p - ACT_POS;
    return 10'(x);
  endfunction

  function automatic logic exp_active(input int p);
    return p >= ACT_POS;
  endfunction

  function automatic logic exp_sync(input int p);
    return !(p >= H_FRONT && p < H_FRONT + H_SYNC);
  endfunction

  function automatic logic exp_tick(input int d);
    return d == PIX_DIV - 1;
  endfunction

  function automatic logic exp_line_end(input int d, input int p);
    return (d == PIX_DIV - 1) && (p == ACT_POS - 1);
  endfunction

  // Advances the model across one rising edge.
  task automatic model_edge(input logic srst);
    if (srst) begin
      m_div = 0;
      m_pos = ACT_POS;
    end else begin
      if (m_div == PIX_DIV - 1) m_pos = (m_pos + 1) % LINE;
      m_div = (m_div + 1) % PIX_DIV;
    end
  endtask

  // Applies a reset pulse and releases it on a falling edge.
  task automatic do_reset;
    @(negedge clk);
    rst_n     = 1'b0;
    sync_rst  = 1'b0;
    sync_rst1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_div = 0;
    m_pos = 0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; sync_rst = 1'b0; sync_rst1 = 1'b0;
    #12;
    checks++; if (tick !== 1'b0)     begin errors++; $display("FAIL reset_tick got %b want 0", tick); end
    checks++; if (h_count !== 10'd0) begin errors++; $display("FAIL reset_h_count got %0d want 0", h_count); end
    checks++; if (active !== 1'b0)   begin errors++; $display("FAIL reset_active got %b want 0", active); end
    checks++; if (sync_n !== 1'b1)   begin errors++; $display("FAIL reset_sync got %b want 1", sync_n); end
    checks++; if (line_end !== 1'b0) begin errors++; $display("FAIL reset_line_end got %b want 0", line_end); end
    checks++; if (tick1 !== 1'b1)    begin errors++; $display("FAIL reset_tick_div1 got %b want 1", tick1); end
  endtask

  // Counts edges after reset release. first_tick names the edge that
  // consumes the first tick.
  task automatic test_reset_release;
    int first_tick = 0;
    int sync_fall  = 0;
    int act_start  = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 700; k++) begin
      @(posedge clk); #1;
      if (tick && first_tick == 0) first_tick = k + 1;
      if (!sync_n && sync_fall == 0) sync_fall = k;
      if (active && act_start == 0) act_start = k;
    end
    checks++; if (first_tick != 4) begin errors++; $display("FAIL release_first_tick got %0d want 4", first_tick); end
    checks++; if (sync_fall != 64) begin errors++; $display("FAIL release_sync_fall got %0d want 64", sync_fall); end
    checks++; if (act_start != 640) begin errors++; $display("FAIL release_active_start got %0d want 640", act_start); end
  endtask

  task automatic test_free_line;
    bit found = 0;
    int le_cnt = 0, le_last = 0, sync_low = 0, act_hi = 0;
    for (int k = 0; k < 4000 && !found; k++) begin
      @(posedge clk); #1;
      if (line_end) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL line_first_end got none want pulse within 4000 clocks"); end
    for (int k = 1; k <= 4 * LINE; k++) begin
      @(posedge clk); #1;
      if (line_end) begin le_cnt++; le_last = k; end
      if (!sync_n) sync_low++;
      if (active) act_hi++;
    end
    checks++; if (le_cnt != 1)     begin errors++; $display("FAIL line_end_count got %0d want 1", le_cnt); end
    checks++; if (le_last != 3200) begin errors++; $display("FAIL line_period got %0d want 3200", le_last); end
    checks++; if (sync_low != 384) begin errors++; $display("FAIL line_sync_low got %0d want 384", sync_low); end
    checks++; if (act_hi != 2560)  begin errors++; $display("FAIL line_active_high got %0d want 2560", act_hi); end
  endtask

  task automatic test_sync_rst_front_porch;
    int first_tick = 0;
    bit le_seen = 0;
    do_reset();
    repeat (30) @(posedge clk);
    @(negedge clk);
    checks++; if (active !== 1'b0 || sync_n !== 1'b1)
      begin errors++; $display("FAIL fp_before_restart got active=%b sync=%b want 0 1", active, sync_n); end
    sync_rst = 1'b1;
    @(posedge clk); #1;
    sync_rst = 1'b0;
    checks++; if (active !== 1'b1)   begin errors++; $display("FAIL fp_restart_active got %b want 1", active); end
    checks++; if (h_count !== 10'd0) begin errors++; $display("FAIL fp_restart_h_count got %0d want 0", h_count); end
    le_seen = line_end;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      le_seen |= line_end;
      if (tick && first_tick == 0) first_tick = k + 1;
    end
    checks++; if (le_seen)         begin errors++; $display("FAIL fp_restart_line_end got 1 want 0"); end
    checks++; if (first_tick != 4) begin errors++; $display("FAIL fp_restart_first_tick got %0d want 4", first_tick); end
  endtask

  task automatic test_sync_rst_line_end;
    bit found = 0;
    int pulses = 0;
    for (int k = 0; k < 4000 && !found; k++) begin
      @(negedge clk);
      if (line_end) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL coincide_find got none want line_end within 4000 clocks"); end
    sync_rst = 1'b1;
    #1;
    checks++; if (line_end !== 1'b1) begin errors++; $display("FAIL coincide_line_end got %b want 1", line_end); end
    if (line_end) pulses++;
    @(posedge clk); #1;
    sync_rst = 1'b0;
    checks++; if (active !== 1'b1)   begin errors++; $display("FAIL coincide_active got %b want 1", active); end
    checks++; if (h_count !== 10'd0) begin errors++; $display("FAIL coincide_h_count got %0d want 0", h_count); end
    if (line_end) pulses++;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (line_end) pulses++;
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL coincide_pulses got %0d want 1", pulses); end
  endtask

  task automatic test_async_reset_active;
    bit found = 0;
    do_reset();
    for (int k = 0; k < 3000 && !found; k++) begin
      @(negedge clk);
      if (active && h_count == 10'd300) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL areset_find got none want x=300 within 3000 clocks"); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (tick !== 1'b0)     begin errors++; $display("FAIL areset_tick got %b want 0", tick); end
    checks++; if (h_count !== 10'd0) begin errors++; $display("FAIL areset_h_count got %0d want 0", h_count); end
    checks++; if (active !== 1'b0)   begin errors++; $display("FAIL areset_active got %b want 0", active); end
    checks++; if (sync_n !== 1'b1)   begin errors++; $display("FAIL areset_sync got %b want 1", sync_n); end
    checks++; if (line_end !== 1'b0) begin errors++; $display("FAIL areset_line_end got %b want 0", line_end); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Random restarts. They are more likely on a line-end cycle so that the
  // coincident case appears.
  task automatic test_random;
    logic srst;
    do_reset();
    for (int c = 0; c < 6000; c++) begin
      checks++;
      if (tick !== exp_tick(m_div) || h_count !== exp_h(m_pos) ||
          active !== exp_active(m_pos) || sync_n !== exp_sync(m_pos) ||
          line_end !== exp_line_end(m_div, m_pos)) begin
        errors++;
        $display("FAIL random_cycle_%0d got tick=%b h=%0d act=%b sync=%b le=%b want tick=%b h=%0d act=%b sync=%b le=%b",
                 c, tick, h_count, active, sync_n, line_end,
                 exp_tick(m_div), exp_h(m_pos), exp_active(m_pos), exp_sync(m_pos),
                 exp_line_end(m_div, m_pos));
      end
      if (exp_line_end(m_div, m_pos)) srst = ($urandom_range(0, 2) == 0);
      else                            srst = ($urandom_range(0, 299) == 0);
      sync_rst = srst;
      model_edge(srst);
      @(negedge clk);
    end
    sync_rst = 1'b0;
  endtask

  task automatic test_pix_div1;
    bit found = 0;
    int tick_low = 0, le_cnt = 0, le_last = 0, sync_low = 0;
    do_reset();
    for (int k = 0; k < 1000 && !found; k++) begin
      @(posedge clk); #1;
      if (!tick1) tick_low++;
      if (line_end1) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL div1_first_end got none want pulse within 1000 clocks"); end
    for (int k = 1; k <= LINE; k++) begin
      @(posedge clk); #1;
      if (!tick1) tick_low++;
      if (line_end1) begin le_cnt++; le_last = k; end
      if (!sync_n1) sync_low++;
    end
    checks++; if (tick_low != 0)  begin errors++; $display("FAIL div1_tick_low got %0d want 0", tick_low); end
    checks++; if (le_cnt != 1)    begin errors++; $display("FAIL div1_line_end_count got %0d want 1", le_cnt); end
    checks++; if (le_last != 800) begin errors++; $display("FAIL div1_line_period got %0d want 800", le_last); end
    checks++; if (sync_low != 96) begin errors++; $display("FAIL div1_sync_low got %0d want 96", sync_low); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout want run to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_reset_release();
    test_free_line();
    test_sync_rst_front_porch();
    test_sync_rst_line_end();
    test_async_reset_active();
    test_random();
    test_pix_div1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
